// File: rtl/alu_9bit_pkg.sv
// Shared word type for the 9-bit ALU result path.
package alu_9bit_pkg;
  localparam int WORD_W = 9;
  typedef logic [WORD_W-1:0] word9_t;
endpackage

// File: rtl/fifo_9bit.sv
// Synchronous FIFO of 9-bit words; a push is visible at dout one cycle later.
// Push is ignored when full and pop is ignored when empty; dout reads 0 while empty.
module fifo_9bit
  import alu_9bit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  word9_t din,
  output word9_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates the full and empty cases when the index bits match.
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  word9_t      mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/demux_9bit_stream.sv
// Steers each 9-bit word to output A or B through a per-output FIFO; one cycle in-to-out.
// in_ready drops only when the selected FIFO is full, so a stalled consumer blocks only its own words.
module demux_9bit_stream
  import alu_9bit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  word9_t           in_data,
  input  logic             in_select,
  output logic             a_valid,
  input  logic             a_ready,
  output word9_t           a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output word9_t           b_data,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);
  logic             full_a, empty_a, full_b, empty_b;
  logic             push_a, push_b;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  // Ready ignores a same-cycle pop on the target FIFO: no pass-through when full.
  assign in_ready = in_select ? !full_b : !full_a;
  assign push_a   = in_valid && in_ready && !in_select;
  assign push_b   = in_valid && in_ready &&  in_select;
  assign a_valid  = !empty_a;
  assign b_valid  = !empty_b;
  assign cnt_a    = cnt_a_q;
  assign cnt_b    = cnt_b_q;

  fifo_9bit #(.DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_a),
    .pop   (a_ready),
    .din   (in_data),
    .dout  (a_data),
    .full  (full_a),
    .empty (empty_a)
  );

  fifo_9bit #(.DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_b),
    .pop   (b_ready),
    .din   (in_data),
    .dout  (b_data),
    .full  (full_b),
    .empty (empty_b)
  );

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (push_a) cnt_a_d = cnt_a_q + CNT_W'(1);
    if (push_b) cnt_b_d = cnt_b_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end
endmodule
